// File: rtl/therm_dwa.sv
// Data-weighted-averaging rotator for a 31-element unit DAC: rotates each
// accepted thermometer code by a running pointer and flags malformed codes.
module therm_dwa #(
  parameter int N  = 31,
  parameter int PW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          dem_en,
  input  logic [N-1:0]  in,
  output logic [N-1:0]  out,
  output logic [PW-1:0] ptr,
  output logic          err
);

  logic [N-1:0]   in_inc;
  logic           valid;
  logic [PW-1:0]  count;
  logic [2*N-1:0] rot_wide;
  logic [N-1:0]   rotated;
  logic [PW:0]    ptr_sum;
  logic [PW-1:0]  ptr_next;

  // Valid iff ones are contiguous from bit 0; all-ones wraps in_inc to zero.
  always_comb begin
    in_inc = in + N'(1);
    valid  = ((in & in_inc) == '0);
  end

  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < N; i++) begin
      count = count + PW'(in[i]);
    end
  end

  // Shifting a doubled copy makes the upper half a rotate-left by ptr within N bits.
  always_comb begin
    rot_wide = {in, in} << ptr;
    rotated  = rot_wide[2*N-1:N];
  end

  always_comb begin
    ptr_sum = {1'b0, ptr} + {1'b0, count};
    if (ptr_sum >= (PW+1)'(N)) begin
      ptr_sum = ptr_sum - (PW+1)'(N);
    end
    ptr_next = ptr_sum[PW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out <= '0;
      ptr <= '0;
      err <= 1'b0;
    end else if (en) begin
      if (!valid) begin
        err <= 1'b1;
      end else if (dem_en) begin
        out <= rotated;
        ptr <= ptr_next;
        err <= 1'b0;
      end else begin
        out <= in;
        ptr <= '0;
        err <= 1'b0;
      end
    end
  end

endmodule

// File: doc/therm_dwa.md
Name: therm_dwa

Overview:
- Downstream stage of the 5-bit binary-to-31-bit thermometer encoder.
- Consumes the thermometer code and applies data-weighted averaging (DWA) rotation before the code drives the 31 unit elements of the DAC.
- Keeps a rotating start pointer so successive codes select adjacent unit elements, first-order shaping element-mismatch error.
- Registered output; flags malformed thermometer inputs.

Parameters:
- N, 31, number of unit elements; equals the thermometer width.
- PW, 5, pointer and count width; N <= 2^PW - 1 is required.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- en  input  1  input-valid strobe; the input is consumed only on a cycle with en=1.
- dem_en  input  1  1 = DWA rotation active; 0 = bypass (input registered unrotated).
- in  input  N  thermometer code; ones are contiguous from bit 0.
- out  output  N  registered unit-element select.
- ptr  output  PW  current rotation pointer, range 0..N-1.
- err  output  1  registered flag: the last accepted input was not a valid thermometer code.

Behaviour:
- Reset (rst=1 at a rising edge): out=0, ptr=0, err=0. Reset has priority over en. A reset mid-sequence discards the pending pointer; the next accepted code starts at bit 0.
- Validity check: `in` is valid iff in & (in+1) == 0, i.e. the ones are contiguous from bit 0. All-zero and all-ones are valid.
- count = number of ones in `in`, range 0..N, width PW.
- Cycle with en=1, valid input, dem_en=1:
  - out <= in rotated left by ptr within N bits. Bit (ptr+k) mod N is set for k = 0..count-1.
  - ptr <= (ptr + count) mod N. Implement as a PW+1-bit sum with a single conditional subtract of N.
  - err <= 0.
- Cycle with en=1, valid input, dem_en=0:
  - out <= in (no rotation).
  - ptr <= 0.
  - err <= 0.
- Cycle with en=1, invalid input (either dem_en):
  - out holds its previous value.
  - ptr holds.
  - err <= 1.
- Cycle with en=0: out, ptr and err all hold.
- Latency: exactly 1 clock from an accepted `in` to `out`/`err`. ptr updates on the same edge, so the new ptr applies to the next accepted code.
- Boundaries:
  - count=0: out=0, ptr unchanged.
  - count=N: out all ones, ptr unchanged, since (ptr+N) mod N = ptr.
  - Wrap-around: set bits continue from bit N-1 to bit 0.
- dem_en toggling 1->0 forces ptr to 0 on the next accepted valid code. Toggling 0->1 resumes rotation from ptr=0.
- The number of ones on `out` always equals count of the last accepted valid input.
- No combinational path from any input to any output.

Test Plan:
- Reset/idle: assert rst for 2 cycles with en=1 and in=0x7FFFFFFF -> out=0, ptr=0, err=0. Then hold en=0 for 5 cycles -> all outputs unchanged.
- Rotation sequence: dem_en=1; apply in=0x1F (count 5) on 7 consecutive cycles.
  - ptr after each edge -> 5, 10, 15, 20, 25, 30, 4.
  - 6th out -> bits 25..29 = 0x3E000000.
  - 7th out -> bits 30, 0..3 = 0x4000000F.
- Wrap with mid-size code: preload ptr=25, apply in=0x3FF (count 10) -> out=0x7E00000F, ptr=4, err=0.
- Extremes: from ptr=7, apply in=0 -> out=0, ptr=7. Then in=0x7FFFFFFF -> out=0x7FFFFFFF, ptr=7.
- Invalid code: ptr=3, out=0x38, then apply in=0x5 -> err=1, out=0x38, ptr=3. The next valid in=0x3 -> err=0, out=0x18, ptr=5.
- Bypass and reset mid-op:
  - dem_en=0, in=0xFF -> out=0xFF, ptr=0.
  - Set dem_en=1, run to ptr=12, then pulse rst with en=1 -> out=0, ptr=0.
  - Next in=0x7 -> out=0x7, ptr=3.
